alu_issue_stage_mips: RTL and testbench
=======================================

// Module: alu_issue_stage_mips
// PURPOSE
//  Decode + issue stage directly upstream of alu_mips. Accepts a MIPS instruction with its register-file
//  operands, decodes it into the ALU's op_type_1/op_type_2/op_type_3 controls and in_1/in_2 operands,
//  and buffers decoded entries in a DEPTH-entry FIFO with valid/ready handshakes on both sides.
//  The output fields connect straight to alu_mips.
// PARAMETERS
//  DEPTH       2   issue FIFO entries; power of 2, >=2
//  DATA_WIDTH  32  operand width; fixed at 32 for MIPS
// PORTS
//  clk            in   1   clock, rising edge
//  reset          in   1   asynchronous, active-low reset
//  in_valid       in   1   instruction + operands valid
//  in_ready       out  1   stage can accept; = (count != DEPTH)
//  in_instruction in   32  MIPS instruction word
//  in_rs_data     in   32  register-file value of rs
//  in_rt_data     in   32  register-file value of rt
//  in_flush       in   1   discard all buffered entries
//  out_valid      out  1   head entry valid
//  out_ready      in   1   downstream consumes the head entry
//  out_op_type_1  out  2   11 logic, 10 arith, 01 SLT, 00 shift
//  out_op_type_2  out  2   logic: 00 AND/01 OR/10 NOR/11 XOR; arith: 00 ADD/01 SUB; shift: 00 logic/01 rotate/10 arith
//  out_op_type_3  out  1   shift direction: 0 left, 1 right
//  out_in_1       out  32  ALU operand 1
//  out_in_2       out  32  ALU operand 2; shift amount for shifts
//  out_dest       out  5   destination register index
//  out_write_en   out  1   = !illegal && dest != 0
//  out_illegal    out  1   undecodable opcode/funct
// BEHAVIOUR
//  Reset (reset=0, async): count=0, pointers=0, out_valid=0, in_ready=1; all out_* fields 0.
//  Push when in_valid&&in_ready; pop when out_valid&&out_ready; push and pop in the same cycle allowed.
//  Latency: an accepted instruction appears at the outputs on the next rising edge. No combinational fall-through.
//  Full (count=DEPTH): in_ready=0, in_valid ignored; a same-cycle pop frees one slot for the next cycle only.
//  Empty: out_valid=0 and all out_* fields driven 0. Pointers wrap modulo DEPTH.
//  Flush: the next edge sets count=0 and pointers=0. A push in that same cycle is dropped; in_flush wins over push and pop.
//  Reset asserted mid-operation discards all entries immediately; no partial entry survives.
//  R-type decode (op=000000), shamt=instr[10:6]:
//   sll 000000 -> shift/logic/left, in_1=rt, in_2=shamt; srl 000010 -> logic/right; sra 000011 -> arith/right
//   srl with instr[21]=1 (rotr) -> rotate/right; sllv/srlv/srav 000100/000110/000111 -> in_2={27'b0,rs[4:0]}
//   add/addu 10000x -> arith ADD; sub/subu 10001x -> arith SUB; in_1=rs, in_2=rt
//   and/or/xor/nor 100100/100101/100110/100111 -> logic AND/OR/XOR/NOR; slt 101010 -> SLT; dest=rd
//  I-type decode, dest=rt, in_1=rs:
//   addi/addiu 00100x -> ADD, in_2=sign-ext imm; slti 001010 -> SLT, in_2=sign-ext imm
//   andi/ori/xori 001100/001101/001110 -> logic, in_2=zero-ext imm
//   lui 001111 -> shift logic left, in_1={16'b0,imm}, in_2=16
//  Any other opcode/funct: out_illegal=1, op fields 0, operands 0, write_en=0. The entry is still queued in order.
//  Overflow trapping is not decoded here; add and addu issue identically.
// TESTING
//  After reset: in_ready=1, out_valid=0, all out_* = 0. Assert reset mid-stream with 2 entries -> count 0 immediately.
//  Push add $3,$1,$2 (rs=13, rt=19) -> next cycle out_op_type_1=10, op2=00, in_1=13, in_2=19, dest=3, write_en=1.
//  Hold out_ready=0 and push 3 instrs -> third stalls (in_ready=0); raise out_ready -> 3 entries emerge in order, none lost.
//  Push sra $4,$5,3 / rotr / lui 0x1234 -> (00,10,1,in_2=3) / (00,01,1) / (00,00,0,in_1=0x1234,in_2=16).
//  Full FIFO + simultaneous push/pop/flush -> count=0 next edge, out_valid=0, pushed entry dropped.
//  Push opcode 111111 -> out_illegal=1, write_en=0; slti $0,$1,-1 -> in_2=0xFFFFFFFF, write_en=0 (dest 0).

Source files
------------

// File: rtl/alu_issue_stage_mips.sv
// rtl/alu_issue_stage_mips.sv - MIPS decode and issue FIFO feeding alu_mips
module alu_issue_stage_mips #(
    parameter int DEPTH      = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instruction,
    input  logic [DATA_WIDTH-1:0] in_rs_data,
    input  logic [DATA_WIDTH-1:0] in_rt_data,
    input  logic                  in_flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:0]            out_op_type_1,
    output logic [1:0]            out_op_type_2,
    output logic                  out_op_type_3,
    output logic [DATA_WIDTH-1:0] out_in_1,
    output logic [DATA_WIDTH-1:0] out_in_2,
    output logic [4:0]            out_dest,
    output logic                  out_write_en,
    output logic                  out_illegal
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [1:0]            t1;
        logic [1:0]            t2;
        logic                  t3;
        logic [DATA_WIDTH-1:0] in1;
        logic [DATA_WIDTH-1:0] in2;
        logic [4:0]            dest;
        logic                  we;
        logic                  ill;
    } entry_t;

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rt_idx;
    logic [4:0]  w_rd_idx;
    logic [4:0]  w_shamt;
    logic [15:0] w_imm;
    logic        w_legal;
    entry_t      w_dec;
    entry_t      w_head;
    logic        w_push;
    logic        w_pop;
    logic        w_unused_bits;

    entry_t         r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;

    assign w_op     = in_instruction[31:26];
    assign w_rt_idx = in_instruction[20:16];
    assign w_rd_idx = in_instruction[15:11];
    assign w_shamt  = in_instruction[10:6];
    assign w_funct  = in_instruction[5:0];
    assign w_imm    = in_instruction[15:0];
    assign w_unused_bits = &{1'b0, in_instruction[25:22]};

    always_comb begin
        w_dec   = '0;
        w_legal = 1'b1;
        if (w_op == 6'b000000) begin
            w_dec.dest = w_rd_idx;
            w_dec.in1  = in_rs_data;
            w_dec.in2  = in_rt_data;
            case (w_funct)
                6'b000000: begin
                    w_dec.in1 = in_rt_data;
                    w_dec.in2 = {{(DATA_WIDTH-5){1'b0}}, w_shamt};
                end
                6'b000010: begin
                    // rs field bit 0 set selects rotr over srl
                    w_dec.t2  = in_instruction[21] ? 2'b01 : 2'b00;
                    w_dec.t3  = 1'b1;
                    w_dec.in1 = in_rt_data;
                    w_dec.in2 = {{(DATA_WIDTH-5){1'b0}}, w_shamt};
                end
                6'b000011: begin
                    w_dec.t2  = 2'b10;
                    w_dec.t3  = 1'b1;
                    w_dec.in1 = in_rt_data;
                    w_dec.in2 = {{(DATA_WIDTH-5){1'b0}}, w_shamt};
                end
                6'b000100: begin
                    w_dec.in1 = in_rt_data;
                    w_dec.in2 = {{(DATA_WIDTH-5){1'b0}}, in_rs_data[4:0]};
                end
                6'b000110: begin
                    w_dec.t3  = 1'b1;
                    w_dec.in1 = in_rt_data;
                    w_dec.in2 = {{(DATA_WIDTH-5){1'b0}}, in_rs_data[4:0]};
                end
                6'b000111: begin
                    w_dec.t2  = 2'b10;
                    w_dec.t3  = 1'b1;
                    w_dec.in1 = in_rt_data;
                    w_dec.in2 = {{(DATA_WIDTH-5){1'b0}}, in_rs_data[4:0]};
                end
                6'b100000, 6'b100001: w_dec.t1 = 2'b10;
                6'b100010, 6'b100011: begin w_dec.t1 = 2'b10; w_dec.t2 = 2'b01; end
                6'b100100: w_dec.t1 = 2'b11;
                6'b100101: begin w_dec.t1 = 2'b11; w_dec.t2 = 2'b01; end
                6'b100110: begin w_dec.t1 = 2'b11; w_dec.t2 = 2'b11; end
                6'b100111: begin w_dec.t1 = 2'b11; w_dec.t2 = 2'b10; end
                6'b101010: w_dec.t1 = 2'b01;
                default:   w_legal = 1'b0;
            endcase
        end else begin
            w_dec.dest = w_rt_idx;
            w_dec.in1  = in_rs_data;
            case (w_op)
                6'b001000, 6'b001001: begin
                    w_dec.t1  = 2'b10;
                    w_dec.in2 = {{(DATA_WIDTH-16){w_imm[15]}}, w_imm};
                end
                6'b001010: begin
                    w_dec.t1  = 2'b01;
                    w_dec.in2 = {{(DATA_WIDTH-16){w_imm[15]}}, w_imm};
                end
                6'b001100: begin
                    w_dec.t1  = 2'b11;
                    w_dec.in2 = {{(DATA_WIDTH-16){1'b0}}, w_imm};
                end
                6'b001101: begin
                    w_dec.t1  = 2'b11;
                    w_dec.t2  = 2'b01;
                    w_dec.in2 = {{(DATA_WIDTH-16){1'b0}}, w_imm};
                end
                6'b001110: begin
                    w_dec.t1  = 2'b11;
                    w_dec.t2  = 2'b11;
                    w_dec.in2 = {{(DATA_WIDTH-16){1'b0}}, w_imm};
                end
                6'b001111: begin
                    w_dec.in1 = {{(DATA_WIDTH-16){1'b0}}, w_imm};
                    w_dec.in2 = DATA_WIDTH'(16);
                end
                default: w_legal = 1'b0;
            endcase
        end
        if (!w_legal) begin
            w_dec     = '0;
            w_dec.ill = 1'b1;
        end else begin
            w_dec.we = (w_dec.dest != 5'd0);
        end
    end

    assign in_ready  = (r_count != CW'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready && !in_flush;
    assign w_pop     = out_valid && out_ready && !in_flush;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_dec;
    end

    // Storage is never cleared; an empty queue masks the head to zero instead.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (in_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    assign w_head        = out_valid ? r_mem[r_rd_ptr] : '0;
    assign out_op_type_1 = w_head.t1;
    assign out_op_type_2 = w_head.t2;
    assign out_op_type_3 = w_head.t3;
    assign out_in_1      = w_head.in1;
    assign out_in_2      = w_head.in2;
    assign out_dest      = w_head.dest;
    assign out_write_en  = w_head.we;
    assign out_illegal   = w_head.ill;
endmodule

// File: tb/tb_alu_issue_stage_mips.sv
// tb/tb_alu_issue_stage_mips.sv - scoreboard bench for alu_issue_stage_mips
module tb_alu_issue_stage_mips;
    localparam int W = 76;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instruction;
    logic [31:0] in_rs_data;
    logic [31:0] in_rt_data;
    logic        in_flush;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_op_type_1;
    logic [1:0]  out_op_type_2;
    logic        out_op_type_3;
    logic [31:0] out_in_1;
    logic [31:0] out_in_2;
    logic [4:0]  out_dest;
    logic        out_write_en;
    logic        out_illegal;

    int          errors = 0;
    int          checks = 0;
    logic [W-1:0] sb_q [$];
    logic [W-1:0] cur_exp;
    logic         accepted;
    logic [W-1:0] obs;
    logic [W-1:0] popped;

    always #5 clk = ~clk;

    alu_issue_stage_mips #(.DEPTH(2), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instruction(in_instruction), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
        .in_flush(in_flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op_type_1(out_op_type_1), .out_op_type_2(out_op_type_2), .out_op_type_3(out_op_type_3),
        .out_in_1(out_in_1), .out_in_2(out_in_2), .out_dest(out_dest),
        .out_write_en(out_write_en), .out_illegal(out_illegal)
    );

    assign obs = {out_op_type_1, out_op_type_2, out_op_type_3, out_in_1, out_in_2,
                  out_dest, out_write_en, out_illegal};

    function automatic logic [W-1:0] ent(input logic [1:0] t1, input logic [1:0] t2,
                                         input logic t3, input logic [31:0] a,
                                         input logic [31:0] b, input logic [4:0] d,
                                         input logic we, input logic ill);
        return {t1, t2, t3, a, b, d, we, ill};
    endfunction

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: sample at negedge, update scoreboard, return just after the posedge.
    task automatic cycle();
        @(negedge clk);
        accepted = 1'b0;
        check("out_valid", W'(out_valid), W'(sb_q.size() != 0));
        check("in_ready", W'(in_ready), W'(sb_q.size() < 2));
        if (sb_q.size() == 0) check("empty_fields", obs, '0);
        if (in_flush) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready && sb_q.size() != 0) begin
                popped = sb_q.pop_front();
                check("entry", obs, popped);
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(cur_exp);
                accepted = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [W-1:0] exp);
        in_valid = 1'b1; in_instruction = ins; in_rs_data = rs; in_rt_data = rt; cur_exp = exp;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (accepted) break;
        end
        if (!accepted) check("send_timeout", W'(0), W'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) cycle();
        check("drained", W'(sb_q.size()), W'(0));
        cycle();
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_instruction = '0; in_rs_data = '0;
        in_rt_data = '0; in_flush = 1'b0; out_ready = 1'b1; cur_exp = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", W'(in_ready), W'(1));
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_fields", obs, '0);
        reset = 1'b1;
        @(posedge clk); #1;

        send({6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 32'd13, 32'd19,
             ent(2'b10, 2'b00, 1'b0, 32'd13, 32'd19, 5'd3, 1'b1, 1'b0));
        send({6'd0, 5'd6, 5'd7, 5'd5, 5'd0, 6'h23}, 32'd100, 32'd7,
             ent(2'b10, 2'b01, 1'b0, 32'd100, 32'd7, 5'd5, 1'b1, 1'b0));
        send({6'd0, 5'd1, 5'd2, 5'd10, 5'd0, 6'h27}, 32'hF0F0_0000, 32'h0000_FFFF,
             ent(2'b11, 2'b10, 1'b0, 32'hF0F0_0000, 32'h0000_FFFF, 5'd10, 1'b1, 1'b0));
        send({6'd0, 5'd1, 5'd2, 5'd11, 5'd0, 6'h26}, 32'h1, 32'h2,
             ent(2'b11, 2'b11, 1'b0, 32'h1, 32'h2, 5'd11, 1'b1, 1'b0));
        send({6'd0, 5'd1, 5'd2, 5'd12, 5'd0, 6'h2A}, 32'hFFFF_FFFF, 32'h5,
             ent(2'b01, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'h5, 5'd12, 1'b1, 1'b0));
        drain();

        out_ready = 1'b0;
        send({6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}, 32'd1, 32'd2,
             ent(2'b10, 2'b00, 1'b0, 32'd1, 32'd2, 5'd3, 1'b1, 1'b0));
        send({6'd0, 5'd1, 5'd2, 5'd4, 5'd0, 6'h24}, 32'd3, 32'd4,
             ent(2'b11, 2'b00, 1'b0, 32'd3, 32'd4, 5'd4, 1'b1, 1'b0));
        in_valid = 1'b1; in_instruction = {6'd0, 5'd1, 5'd2, 5'd5, 5'd0, 6'h25};
        in_rs_data = 32'd5; in_rt_data = 32'd6;
        cur_exp = ent(2'b11, 2'b01, 1'b0, 32'd5, 32'd6, 5'd5, 1'b1, 1'b0);
        repeat (3) begin
            cycle();
            check("stall_accept", W'(accepted), W'(0));
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10 && !accepted; i++) cycle();
        check("stall_resume", W'(accepted), W'(1));
        in_valid = 1'b0;
        drain();

        send({6'd0, 5'd0, 5'd5, 5'd4, 5'd3, 6'h03}, 32'd0, 32'h8000_0000,
             ent(2'b00, 2'b10, 1'b1, 32'h8000_0000, 32'd3, 5'd4, 1'b1, 1'b0));
        send({6'd0, 5'd1, 5'd7, 5'd6, 5'd8, 6'h02}, 32'd0, 32'h1234_5678,
             ent(2'b00, 2'b01, 1'b1, 32'h1234_5678, 32'd8, 5'd6, 1'b1, 1'b0));
        send({6'b001111, 5'd0, 5'd8, 16'h1234}, 32'hDEAD_BEEF, 32'd0,
             ent(2'b00, 2'b00, 1'b0, 32'h0000_1234, 32'd16, 5'd8, 1'b1, 1'b0));
        send({6'd0, 5'd2, 5'd3, 5'd9, 5'd0, 6'h06}, 32'hFFFF_FFE5, 32'hAAAA_5555,
             ent(2'b00, 2'b00, 1'b1, 32'hAAAA_5555, 32'd5, 5'd9, 1'b1, 1'b0));
        send({6'd0, 5'd0, 5'd3, 5'd9, 5'd31, 6'h00}, 32'd0, 32'h1,
             ent(2'b00, 2'b00, 1'b0, 32'h1, 32'd31, 5'd9, 1'b1, 1'b0));
        send({6'b001101, 5'd1, 5'd2, 16'h8001}, 32'h10, 32'd0,
             ent(2'b11, 2'b01, 1'b0, 32'h10, 32'h0000_8001, 5'd2, 1'b1, 1'b0));
        send({6'b001000, 5'd1, 5'd2, 16'h8001}, 32'h10, 32'd0,
             ent(2'b10, 2'b00, 1'b0, 32'h10, 32'hFFFF_8001, 5'd2, 1'b1, 1'b0));
        send({6'b111111, 26'h3FF_FFFF}, 32'h55, 32'h66,
             ent(2'b00, 2'b00, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1));
        send({6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h3F}, 32'h55, 32'h66,
             ent(2'b00, 2'b00, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1));
        send({6'b001010, 5'd1, 5'd0, 16'hFFFF}, 32'd7, 32'd0,
             ent(2'b01, 2'b00, 1'b0, 32'd7, 32'hFFFF_FFFF, 5'd0, 1'b0, 1'b0));
        drain();

        out_ready = 1'b0;
        send({6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 32'd1, 32'd1,
             ent(2'b10, 2'b00, 1'b0, 32'd1, 32'd1, 5'd3, 1'b1, 1'b0));
        send({6'd0, 5'd1, 5'd2, 5'd4, 5'd0, 6'h20}, 32'd2, 32'd2,
             ent(2'b10, 2'b00, 1'b0, 32'd2, 32'd2, 5'd4, 1'b1, 1'b0));
        in_valid = 1'b1; out_ready = 1'b1; in_flush = 1'b1;
        cur_exp = ent(2'b10, 2'b00, 1'b0, 32'd2, 32'd2, 5'd4, 1'b1, 1'b0);
        cycle();
        in_flush = 1'b0; in_valid = 1'b0;
        cycle();
        check("flush_full_empty", W'(out_valid), W'(0));

        out_ready = 1'b0;
        send({6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 32'd9, 32'd9,
             ent(2'b10, 2'b00, 1'b0, 32'd9, 32'd9, 5'd3, 1'b1, 1'b0));
        in_valid = 1'b1; in_flush = 1'b1;
        cycle();
        in_flush = 1'b0; in_valid = 1'b0;
        cycle();
        check("flush_push_dropped", W'(out_valid), W'(0));
        drain();

        out_ready = 1'b0;
        send({6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 32'd1, 32'd2,
             ent(2'b10, 2'b00, 1'b0, 32'd1, 32'd2, 5'd3, 1'b1, 1'b0));
        send({6'd0, 5'd1, 5'd2, 5'd4, 5'd0, 6'h20}, 32'd3, 32'd4,
             ent(2'b10, 2'b00, 1'b0, 32'd3, 32'd4, 5'd4, 1'b1, 1'b0));
        check("full_before_reset", W'(in_ready), W'(0));
        reset = 1'b0;
        #1;
        check("mid_rst_out_valid", W'(out_valid), W'(0));
        check("mid_rst_in_ready", W'(in_ready), W'(1));
        check("mid_rst_fields", obs, '0);
        sb_q.delete();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        cycle();
        out_ready = 1'b1;
        send({6'd0, 5'd1, 5'd2, 5'd7, 5'd0, 6'h22}, 32'd50, 32'd8,
             ent(2'b10, 2'b01, 1'b0, 32'd50, 32'd8, 5'd7, 1'b1, 1'b0));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
